// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Single-issue front end for an external combinational ALU. Accepts one
//   instruction at a time, decodes it into an ALU selector and two operands,
//   waits one cycle for the ALU to settle, then captures the ALU result,
//   zero flag and branch decision into a response held until it is consumed.
//
// Ports:
//   i_clk               clock, all state changes on the rising edge
//   i_reset             synchronous active-high reset
//   i_req_valid         instruction request present
//   o_req_ready         block can accept a request (IDLE only)
//   i_opcode / i_funct  instruction opcode and R-type function fields
//   i_rs_data           first register operand
//   i_rt_data           second register operand
//   i_imm               16-bit immediate field
//   o_alu_sel           operation selector to the ALU
//   o_alu_a / o_alu_b   ALU operands (registered at accept)
//   i_alu_c             combinational ALU result
//   i_alu_zero          ALU zero flag
//   o_rsp_valid         response present (RESP only)
//   i_rsp_ready         consumer accepts the response
//   o_rsp_result        captured result
//   o_rsp_zero          captured zero flag
//   o_rsp_branch_taken  branch decision for beq/bne, 0 otherwise
//   o_rsp_illegal       request did not decode
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a request, req_ready=1
//   EXEC   | decoded operands drive the ALU, result settles
//   RESP   | response held, rsp_valid=1, waits for rsp_ready
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [5:0]             i_opcode,
    input  logic [5:0]             i_funct,
    input  logic [WORD_LENGTH-1:0] i_rs_data,
    input  logic [WORD_LENGTH-1:0] i_rt_data,
    input  logic [15:0]            i_imm,
    output logic [3:0]             o_alu_sel,
    output logic [WORD_LENGTH-1:0] o_alu_a,
    output logic [WORD_LENGTH-1:0] o_alu_b,
    input  logic [WORD_LENGTH-1:0] i_alu_c,
    input  logic                   i_alu_zero,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [WORD_LENGTH-1:0] o_rsp_result,
    output logic                   o_rsp_zero,
    output logic                   o_rsp_branch_taken,
    output logic                   o_rsp_illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_MULT = 4'b0010;
    localparam logic [3:0] SEL_AND  = 4'b0101;
    localparam logic [3:0] SEL_OR   = 4'b0110;
    localparam logic [3:0] SEL_LUI  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1001;
    localparam logic [3:0] SEL_ILL  = 4'b1111;

    // operand sources chosen by the decoder
    typedef enum logic [1:0] {
        B_RT   = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2
    } b_src_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_accept;
    logic                     w_capture;

    logic [3:0]               w_dec_sel;
    logic                     w_dec_legal;
    b_src_t                   w_dec_b_src;
    br_kind_t                 w_dec_br;
    logic [WORD_LENGTH-1:0]   w_imm_sext;
    logic [WORD_LENGTH-1:0]   w_imm_zext;
    logic [WORD_LENGTH-1:0]   w_dec_a;
    logic [WORD_LENGTH-1:0]   w_dec_b;

    logic [3:0]               r_alu_sel;
    logic [WORD_LENGTH-1:0]   r_alu_a;
    logic [WORD_LENGTH-1:0]   r_alu_b;
    br_kind_t                 r_br_kind;
    logic                     r_illegal;

    logic [WORD_LENGTH-1:0]   r_rsp_result;
    logic                     r_rsp_zero;
    logic                     r_rsp_branch_taken;
    logic                     r_rsp_illegal;

    // WORD_LENGTH is assumed to be wider than the 16-bit immediate.
    assign w_imm_sext = {{(WORD_LENGTH-16){i_imm[15]}}, i_imm};
    assign w_imm_zext = {{(WORD_LENGTH-16){1'b0}}, i_imm};

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_sel   = SEL_ILL;
        w_dec_legal = 1'b0;
        w_dec_b_src = B_RT;
        w_dec_br    = BR_NONE;
        case (i_opcode)
            OP_RTYPE: begin
                w_dec_legal = 1'b1;
                case (i_funct)
                    FN_ADD:  w_dec_sel = SEL_ADD;
                    FN_SUB:  w_dec_sel = SEL_SUB;
                    FN_MULT: w_dec_sel = SEL_MULT;
                    FN_AND:  w_dec_sel = SEL_AND;
                    FN_OR:   w_dec_sel = SEL_OR;
                    FN_SLT:  w_dec_sel = SEL_SLT;
                    default: begin
                        w_dec_sel   = SEL_ILL;
                        w_dec_legal = 1'b0;
                    end
                endcase
            end
            OP_BEQ: begin
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_SUB;
                w_dec_br    = BR_EQ;
            end
            OP_BNE: begin
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_SUB;
                w_dec_br    = BR_NE;
            end
            OP_ADDI: begin
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_ADD;
                w_dec_b_src = B_SEXT;
            end
            OP_SLTI: begin
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_SLT;
                w_dec_b_src = B_SEXT;
            end
            OP_ANDI: begin
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_AND;
                w_dec_b_src = B_ZEXT;
            end
            OP_ORI: begin
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_OR;
                w_dec_b_src = B_ZEXT;
            end
            OP_LUI: begin
                // the ALU performs the upper-half placement itself
                w_dec_legal = 1'b1;
                w_dec_sel   = SEL_LUI;
                w_dec_b_src = B_ZEXT;
            end
            default: begin
                w_dec_sel   = SEL_ILL;
                w_dec_legal = 1'b0;
            end
        endcase
    end

    // Illegal requests present zero operands so nothing stale reaches the ALU.
    always_comb begin
        w_dec_a = '0;
        w_dec_b = '0;
        if (w_dec_legal) begin
            w_dec_a = i_rs_data;
            case (w_dec_b_src)
                B_SEXT:  w_dec_b = w_imm_sext;
                B_ZEXT:  w_dec_b = w_imm_zext;
                default: w_dec_b = i_rt_data;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Issue registers: loaded only on accept
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_sel <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_br_kind <= BR_NONE;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_alu_sel <= w_dec_sel;
            r_alu_a   <= w_dec_a;
            r_alu_b   <= w_dec_b;
            r_br_kind <= w_dec_br;
            r_illegal <= ~w_dec_legal;
        end
    end

    // ------------------------------------------------------------------
    // Response registers: loaded on the EXEC->RESP edge, held through RESP
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_result       <= '0;
            r_rsp_zero         <= 1'b0;
            r_rsp_branch_taken <= 1'b0;
            r_rsp_illegal      <= 1'b0;
        end else if (w_capture) begin
            if (r_illegal) begin
                r_rsp_result       <= '0;
                r_rsp_zero         <= 1'b1;
                r_rsp_branch_taken <= 1'b0;
                r_rsp_illegal      <= 1'b1;
            end else begin
                r_rsp_result  <= i_alu_c;
                r_rsp_zero    <= i_alu_zero;
                r_rsp_illegal <= 1'b0;
                case (r_br_kind)
                    BR_EQ:   r_rsp_branch_taken <= i_alu_zero;
                    BR_NE:   r_rsp_branch_taken <= ~i_alu_zero;
                    default: r_rsp_branch_taken <= 1'b0;
                endcase
            end
        end
    end

    assign o_alu_sel          = r_alu_sel;
    assign o_alu_a            = r_alu_a;
    assign o_alu_b            = r_alu_b;
    assign o_rsp_result       = r_rsp_result;
    assign o_rsp_zero         = r_rsp_zero;
    assign o_rsp_branch_taken = r_rsp_branch_taken;
    assign o_rsp_illegal      = r_rsp_illegal;

endmodule
